serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 105 ++++++++++
 tb/tb_serial_adder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: processes one operand bit per clock, LSB first, and
// presents the WIDTH-bit sum and carry out with a one-cycle done pulse.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next_c;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             sum_bit_c;
  logic             carry_next_c;
  logic             last_c;

  // One full-adder slice on the current LSBs
  always_comb begin
    sum_bit_c    = a_sh[0] ^ b_sh[0] ^ carry;
    carry_next_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    res_next_c   = {sum_bit_c, res_sh[WIDTH-1:1]};
    last_c       = (cnt == CNT_W'(WIDTH - 1));
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_c) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register with registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  // Operand shifters, carry, counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next_c;
          carry  <= carry_next_c;
          cnt    <= cnt + CNT_W'(1);
          if (last_c) begin
            sum  <= res_next_c;
            cout <= carry_next_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed and random additions
// compared against a plain-arithmetic reference.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one addition and follow it to completion; noise drives start and
  // new operands during the run, which must all be ignored.
  task automatic run_op(input logic [W-1:0] opa, input logic [W-1:0] opb, input bit noise);
    int unsigned s;
    int unsigned exp_sum;
    int unsigned exp_cout;
    int edges;
    int busy_cnt;
    bit held;
    logic [W-1:0] prev_sum;
    logic prev_cout;
    s        = int'(opa) + int'(opb);
    exp_sum  = s % (1 << W);
    exp_cout = s >> W;
    prev_sum  = sum;
    prev_cout = cout;
    held      = 1'b1;
    a = opa;
    b = opb;
    start = 1'b1;
    step();
    start = 1'b0;
    edges = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && edges < 4 * W) begin
      if (noise) begin
        a = W'($urandom);
        b = W'($urandom);
        start = 1'b1;
      end
      if (sum !== prev_sum || cout !== prev_cout) held = 1'b0;
      step();
      edges++;
      if (busy) busy_cnt++;
    end
    check("done_latency", 32'(edges), 32'(W));
    check("busy_cycles", 32'(busy_cnt), 32'(W));
    check("held_during_run", 32'(held), 32'd1);
    check("sum", 32'(sum), exp_sum);
    check("cout", 32'(cout), exp_cout);
    step();
    start = 1'b0;
    check("done_one_cycle", 32'(done), 32'd0);
    check("no_relaunch_from_done", 32'(busy), 32'd0);
    step();
    check("idle_after_done", 32'(busy), 32'd0);
    check("sum_held_idle", 32'(sum), exp_sum);
  endtask

  initial begin
    int pulses;
    int last_pulse;
    int edges;
    bit saw_done;
    bit stable;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    step();

    // Directed corner cases
    run_op(8'd3, 8'd5, 1'b0);
    run_op(8'd255, 8'd1, 1'b0);
    run_op(8'd255, 8'd255, 1'b0);
    run_op(8'd0, 8'd0, 1'b0);
    run_op(8'd10, 8'd20, 1'b1);

    // Reset mid-run aborts with no done pulse
    a = 8'd200;
    b = 8'd100;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      if (done || busy) saw_done = 1'b1;
      step();
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    run_op(8'd1, 8'd2, 1'b0);

    // Reset beats start on the same edge
    rst = 1'b1;
    start = 1'b1;
    step();
    check("rst_over_start", 32'(busy), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    step();
    check("rst_over_start_idle", 32'(busy), 32'd0);

    // Continuous start: one result every W+2 cycles
    a = 8'd7;
    b = 8'd9;
    start = 1'b1;
    pulses = 0;
    last_pulse = -1;
    stable = 1'b1;
    edges = 0;
    while (pulses < 4 && edges < 20 * W) begin
      step();
      edges++;
      if (pulses > 0 && sum !== 8'd16) stable = 1'b0;
      if (done) begin
        check("stream_sum", 32'(sum), 32'd16);
        if (last_pulse >= 0) check("stream_period", 32'(edges - last_pulse), 32'(W + 2));
        last_pulse = edges;
        pulses++;
      end
    end
    check("stream_pulses", 32'(pulses), 32'd4);
    check("stream_stable", 32'(stable), 32'd1);
    start = 1'b0;
    for (int i = 0; i < W + 4; i++) step();
    check("stream_idle", 32'(busy), 32'd0);

    // Random operands, alternating quiet and noisy runs
    for (int i = 0; i < 24; i++) begin
      run_op(W'($urandom), W'($urandom), (i % 2) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
